// File: rtl/clock_display_driver_pkg.sv
// Shared constants, types and BCD helper for the clock display driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam digit_idx_t SEP_IDX_MIN = 3'd2;
    localparam digit_idx_t SEP_IDX_HRS = 3'd4;
    localparam digit_idx_t LAST_IDX    = 3'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Five conditional subtract-by-10 stages cover every in-range value (0..59).
    function automatic bcd_t bcd_split(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        bcd_t       res;
        r = v;
        t = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        res.tens = t;
        res.ones = r[3:0];
        return res;
    endfunction

endpackage

// File: rtl/clock_display_driver_if.sv
// Time-of-day input bus plus multiplexed seven-segment display pins.
// Latency: n/a (wiring only).
// Backpressure: none; the display side samples the time bus once per frame.
interface clock_display_driver_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hrs;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    modport master (
        output sec, min, hrs,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  sec, min, hrs,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/clock_display_driver_seg7_encoder.sv
// Digit to active-high seven-segment pattern; dash overrides blank.
// Latency: combinational.
// Backpressure: none.
module seg7_encoder
    import clock_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/clock_display_driver.sv
// HH.MM.SS six-digit multiplexed display driver; LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
// Latency: 1 cycle from digit index to pins; inputs snapshotted once per frame.
// Backpressure: none; time inputs are sampled only on the frame wrap.
module clock_display_driver
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    clock_display_driver_if.slave  disp
);

    localparam int              PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [5:0]      AN_OFF  = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

    logic [PW-1:0] ps_cnt;
    logic          tick;
    digit_idx_t    idx;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hrs;

    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PW'(1);
        end
    end

    // Snapshot on the wrap so a whole frame always shows one coherent time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx             <= '0;
            snap_sec        <= '0;
            snap_min        <= '0;
            snap_hrs        <= '0;
            disp.frame_done <= 1'b0;
        end else begin
            disp.frame_done <= 1'b0;
            if (tick) begin
                if (idx == LAST_IDX) begin
                    idx             <= '0;
                    snap_sec        <= disp.sec;
                    snap_min        <= disp.min;
                    snap_hrs        <= disp.hrs;
                    disp.frame_done <= 1'b1;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    bcd_t sec_bcd;
    bcd_t min_bcd;
    bcd_t hrs_bcd;
    logic sec_bad;
    logic min_bad;
    logic hrs_bad;

    assign sec_bcd = bcd_split(snap_sec);
    assign min_bcd = bcd_split(snap_min);
    assign hrs_bcd = bcd_split({1'b0, snap_hrs});
    assign sec_bad = (snap_sec > 6'd59);
    assign min_bad = (snap_min > 6'd59);
    assign hrs_bad = (snap_hrs > 5'd23);

    logic [3:0] cur_digit;
    logic       cur_dash;
    logic       cur_blank;

    always_comb begin
        cur_digit = 4'd0;
        cur_dash  = 1'b0;
        cur_blank = 1'b0;
        case (idx)
            3'd0: begin cur_digit = sec_bcd.ones; cur_dash = sec_bad; end
            3'd1: begin cur_digit = sec_bcd.tens; cur_dash = sec_bad; end
            3'd2: begin cur_digit = min_bcd.ones; cur_dash = min_bad; end
            3'd3: begin cur_digit = min_bcd.tens; cur_dash = min_bad; end
            3'd4: begin cur_digit = hrs_bcd.ones; cur_dash = hrs_bad; end
            3'd5: begin
                cur_digit = hrs_bcd.tens;
                cur_dash  = hrs_bad;
`ifdef LEADING_ZERO_BLANK_EN
                cur_blank = (hrs_bcd.tens == 4'd0);
`else
                cur_blank = 1'b0;
`endif
            end
            default: cur_blank = 1'b1;
        endcase
    end

    logic [6:0] seg_hi;
    logic       dp_hi;
    logic [5:0] an_hi;

    seg7_encoder u_enc (
        .digit (cur_digit),
        .blank (cur_blank),
        .dash  (cur_dash),
        .seg   (seg_hi)
    );

    assign dp_hi = (idx == SEP_IDX_MIN) || (idx == SEP_IDX_HRS);
    assign an_hi = 6'b000001 << idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp.seg <= SEG_OFF;
            disp.dp  <= DP_OFF;
            disp.an  <= AN_OFF;
        end else begin
            disp.seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            disp.dp  <= SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
            disp.an  <= AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
        end
    end

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver at SCAN_DIV=4, active-low pins.
// Expected segment words below are already inverted for active-low drive.
module tb_clock_display_driver;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    clock_display_driver_if dif();

    clock_display_driver #(
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (dif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Per-frame expected seg words, packed as {digit5, ..., digit0}.
    localparam logic [41:0] F_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [41:0] F_235959 = {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10};
    localparam logic [41:0] F_ERR    = {7'h3F, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0]  H5_ZERO  = 7'h7F;
`else
    localparam logic [6:0]  H5_ZERO  = 7'h40;
`endif
    localparam logic [41:0] F_070000 = {H5_ZERO, 7'h78, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        dif.hrs = h;
        dif.min = m;
        dif.sec = s;
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dif.frame_done && n < 64);
        check("frame_done_wait", 32'(dif.frame_done), 32'd1);
    endtask

    // Walks one full frame; optionally swaps the inputs mid-frame.
    task automatic check_frame(input string tag, input logic [41:0] exp, input bit chg,
                               input logic [4:0] nh, input logic [5:0] nm, input logic [5:0] ns);
        logic [5:0] an_exp;
        for (int d = 0; d < 6; d++) begin
            an_exp = ~(6'b000001 << d);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check($sformatf("%s d%0d c%0d an", tag, d, c), 32'(dif.an), 32'(an_exp));
                check($sformatf("%s d%0d c%0d seg", tag, d, c), 32'(dif.seg), 32'(exp[d*7 +: 7]));
                check($sformatf("%s d%0d c%0d dp", tag, d, c), 32'(dif.dp),
                      (d == 2 || d == 4) ? 32'd0 : 32'd1);
                check($sformatf("%s d%0d c%0d frame_done", tag, d, c), 32'(dif.frame_done),
                      (d == 5 && c == 3) ? 32'd1 : 32'd0);
                if (chg && d == 2 && c == 3) set_time(nh, nm, ns);
            end
        end
    endtask

    initial begin
        set_time(5'd0, 6'd0, 6'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst seg", 32'(dif.seg), 32'h7F);
        check("rst dp", 32'(dif.dp), 32'd1);
        check("rst an", 32'(dif.an), 32'h3F);
        check("rst frame_done", 32'(dif.frame_done), 32'd0);

        reset = 1'b1;
        set_time(5'd12, 6'd34, 6'd56);
        @(negedge clk);
        check("first an", 32'(dif.an), 32'h3E);
        check("first seg", 32'(dif.seg), 32'h40);
        check("first dp", 32'(dif.dp), 32'd1);
        wait_frame_done();

        check_frame("f123456a", F_123456, 1'b0, 5'd0, 6'd0, 6'd0);
        check_frame("f123456b", F_123456, 1'b1, 5'd23, 6'd59, 6'd59);
        check_frame("f235959", F_235959, 1'b1, 5'd24, 6'd0, 6'd61);
        check_frame("ferr", F_ERR, 1'b1, 5'd7, 6'd0, 6'd0);
        check_frame("f070000", F_070000, 1'b0, 5'd0, 6'd0, 6'd0);

        repeat (13) @(negedge clk);
        check("pre-reset an", 32'(dif.an), 32'h37);
        #1 reset = 1'b0;
        #1;
        check("midrst seg", 32'(dif.seg), 32'h7F);
        check("midrst dp", 32'(dif.dp), 32'd1);
        check("midrst an", 32'(dif.an), 32'h3F);
        check("midrst frame_done", 32'(dif.frame_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart an", 32'(dif.an), 32'h3E);
        check("restart seg", 32'(dif.seg), 32'h40);
        repeat (3) @(negedge clk);
        check("restart hold an", 32'(dif.an), 32'h3E);
        @(negedge clk);
        check("restart next an", 32'(dif.an), 32'h3D);
        check("restart next seg", 32'(dif.seg), 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_display_driver.md
Name: clock_display_driver

Overview:
- Consumer end of the time-of-day counter interface: takes binary sec/min/hrs and drives a 6-digit multiplexed seven-segment display as HH.MM.SS.
- Sits between the time counter and the board display pins.
- Internals: scan prescaler, digit scan counter, per-frame input snapshot (no tearing), binary-to-BCD split and segment encode.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range >= 1.
- SEG_ACTIVE_LOW, 1: 1 = segment and dp pins are driven low when lit.
- AN_ACTIVE_LOW, 1: 1 = anode-select pins are driven low when the digit is enabled.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- sec  in  6  seconds, binary, valid range 0..59
- min  in  6  minutes, binary, valid range 0..59
- hrs  in  5  hours, binary, valid range 0..23
- seg  out  7  segments; bit0 = a ... bit6 = g
- dp  out  1  decimal point / separator
- an  out  6  one-hot digit enable; bit0 = rightmost digit
- frame_done  out  1  one-cycle pulse when a full 6-digit scan completes

Behaviour:
- Reset values:
  - Prescaler = 0, digit index = 0, snapshot registers = 0, frame_done = 0.
  - seg, dp and an are all in the inactive level: with default parameters seg = 7'h7F, dp = 1, an = 6'h3F.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted on the cycle the count equals SCAN_DIV-1.
  - With SCAN_DIV = 1, tick is asserted every cycle.
- Digit index:
  - Advances on tick and wraps 5 -> 0.
  - Digit mapping: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hrs ones, 5 = hrs tens.
- Snapshot and frame_done:
  - On the tick edge where the index wraps 5 -> 0, sec, min and hrs are latched into the snapshot registers.
  - frame_done pulses high for exactly that cycle.
  - Input changes at any other time have no effect until the next wrap.
- Output register:
  - seg, dp and an are registered from the current index and snapshot every cycle.
  - Latency is 1 cycle from an index change to the pins.
  - The first clock after reset release drives digit 0 of snapshot 00:00:00.
- BCD split: tens = value/10 and ones = value%10, implemented as a compare/subtract chain with no divider. Range is 0..59 for sec/min and 0..23 for hrs.
- Segment encoding (active-high, before polarity is applied):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Dash = 40, blank = 00.
- Out-of-range fields: if a snapshot field is out of range (sec > 59, min > 59, hrs > 23), both digits of that field show dash. The other fields are unaffected.
- dp: lit on digit indices 2 and 4 (separators after minutes-ones and hours-ones); dark on all other digits.
- Polarity: seg and dp are inverted when SEG_ACTIVE_LOW = 1; an is inverted when AN_ACTIVE_LOW = 1.
- Reset mid-scan: reset asserted at any time forces all outputs inactive immediately (asynchronous). Scanning restarts at digit 0 after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the snapshot hrs tens digit is 0, digit 5 shows blank (00) instead of "0". The an bit for digit 5 is still scanned so the duty cycle is unchanged.
- Undefined: digit 5 always shows its numeral.

Decomposition:
- Package clock_disp_pkg contains:
  - NUM_DIGITS = 6.
  - Digit-index typedef (3 bits).
  - The 10 segment-pattern constants plus SEG_DASH and SEG_BLANK.
  - Separator digit-index constants 2 and 4.
- One sub-module: seg7_encoder, combinational. Input is a 4-bit digit plus blank/dash flags; output is 7-bit active-high segments.
- Prescaler, scan counter, snapshot, BCD split and output registers stay in the top module.

Test Plan (SCAN_DIV = 4, default polarities):
- Reset low for 3 cycles -> seg = 7F, dp = 1, an = 3F. First clock after release -> an = 3E, seg = 40 (a "0", active-low).
- Inputs 12:34:56 held for 2 frames -> second frame shows digit 0 = "6" (seg = 02), 1 = "5", 2 = "4" with dp = 0, 3 = "3", 4 = "2" with dp = 0, 5 = "1". an walks 3E, 3D, 3B, 37, 2F, 1F, each held 4 cycles.
- Change the inputs mid-frame from 12:34:56 to 23:59:59 -> the current frame still shows 12:34:56; the next frame shows 23:59:59; frame_done pulses once every 24 cycles.
- Input sec = 61, min = 0, hrs = 24 -> digits 0, 1, 4 and 5 show dash (seg = 3F); digits 2 and 3 show "0".
- Assert reset mid-frame at digit 3 -> outputs go inactive in the same cycle; after release, the scan restarts at an = 3E.
- With LEADING_ZERO_BLANK_EN defined and hrs = 7 -> digit 5 seg = 7F while an = 1F; with it undefined, digit 5 shows "0".
